// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA I/O channel.
// Contents: FSM state enum, transfer direction codes, default widths,
// device buffer depth and the device buffer base index used by address decode.
package dma_pkg;

  localparam int unsigned DMA_DATA_W   = 32;
  localparam int unsigned DMA_MEM_AW   = 8;
  localparam int unsigned MAX_WORDS    = 31;
  localparam int unsigned DMA_CNT_W    = $clog2(MAX_WORDS + 1);
  localparam int unsigned DEV_BUF_BASE = 192;

  localparam logic DIR_DEV2MEM = 1'b0;
  localparam logic DIR_MEM2DEV = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_REQ = 3'd1,
    S_XFER_RD  = 3'd2,
    S_XFER_WR  = 3'd3,
    S_DONE     = 3'd4
  } dma_state_t;

endpackage

// File: rtl/dma_io_channel_if.sv
// Bundle of configuration, device-bus and memory-port signals of the channel.
// master: the DMA channel side (drives ack/strobes/status).
// slave : the environment (software config, device, memory).
interface dma_io_channel_if #(
  parameter int unsigned DATA_W = dma_pkg::DMA_DATA_W,
  parameter int unsigned MEM_AW = dma_pkg::DMA_MEM_AW,
  parameter int unsigned CNT_W  = dma_pkg::DMA_CNT_W
) ();

  // software configuration / status
  logic              cfg_start;
  logic              cfg_dir;
  logic [MEM_AW-1:0] cfg_mem_addr;
  logic [CNT_W-1:0]  cfg_len;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  word_count;

  // device bus
  logic              gpio_req;
  logic              ack;
  logic              io_write;
  logic [DATA_W-1:0] dev_rdata;
  logic [DATA_W-1:0] dev_wdata;

  // memory port
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cfg_start, cfg_dir, cfg_mem_addr, cfg_len,
    input  gpio_req, dev_rdata, mem_rdata,
    output busy, done, word_count,
    output ack, io_write, dev_wdata,
    output mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    output cfg_start, cfg_dir, cfg_mem_addr, cfg_len,
    output gpio_req, dev_rdata, mem_rdata,
    input  busy, done, word_count,
    input  ack, io_write, dev_wdata,
    input  mem_addr, mem_re, mem_we, mem_wdata
  );

endinterface

// File: rtl/dma_addr_counter.sv
// Memory address generator and word-index counter for one transfer.
// Ports: clk, rst (async high); load/first/base/len start a transfer
// (first=1 marks word 0 as already issued); inc advances one word.
// addr_c = base + index (wraps mod 2^MEM_AW); at_limit_c = index reached the
// clamped length; last_c = the next increment reaches it.
module dma_addr_counter #(
  parameter int unsigned MEM_AW    = dma_pkg::DMA_MEM_AW,
  parameter int unsigned CNT_W     = dma_pkg::DMA_CNT_W,
  parameter int unsigned MAX_WORDS = dma_pkg::MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              first,
  input  logic [MEM_AW-1:0] base,
  input  logic [CNT_W-1:0]  len,
  input  logic              inc,
  output logic [MEM_AW-1:0] addr_c,
  output logic              at_limit_c,
  output logic              last_c
);

  logic [MEM_AW-1:0] base_q, base_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  limit_q, limit_d;

  // Length 0 (run until request drops) and oversize lengths both cap at the buffer depth.
  always_comb begin
    base_d  = base_q;
    idx_d   = idx_q;
    limit_d = limit_q;
    if (load) begin
      base_d  = base;
      idx_d   = first ? CNT_W'(1) : '0;
      limit_d = ((len == '0) || (len > CNT_W'(MAX_WORDS))) ? CNT_W'(MAX_WORDS) : len;
    end else if (inc) begin
      idx_d = idx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q  <= '0;
      idx_q   <= '0;
      limit_q <= '0;
    end else begin
      base_q  <= base_d;
      idx_q   <= idx_d;
      limit_q <= limit_d;
    end
  end

  assign addr_c     = base_q + MEM_AW'(idx_q);
  assign at_limit_c = (idx_q == limit_q);
  assign last_c     = (CNT_W'(idx_q + CNT_W'(1)) == limit_q);

endmodule

// File: rtl/dma_io_channel.sv
// DMA engine for one buffered I/O device: drains the device buffer into memory
// (dir 0) or fills it from memory (dir 1) under software start control.
// Ports: clk, rst (async high), bus (dma_io_channel_if.master) carrying the
// config/status, device handshake/data and memory port signals.
module dma_io_channel #(
  parameter int unsigned DATA_W    = dma_pkg::DMA_DATA_W,
  parameter int unsigned MEM_AW    = dma_pkg::DMA_MEM_AW,
  parameter int unsigned MAX_WORDS = dma_pkg::MAX_WORDS,
  parameter int unsigned CNT_W     = dma_pkg::DMA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  dma_io_channel_if.master bus
);

  import dma_pkg::*;

  dma_state_t state_q, state_d;

  logic              ack_q, ack_d;
  logic              io_write_q, io_write_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;

  logic              cnt_load, cnt_first, cnt_inc;
  logic [MEM_AW-1:0] cnt_addr_c;
  logic              cnt_at_limit_c, cnt_last_c;

  dma_addr_counter #(
    .MEM_AW    (MEM_AW),
    .CNT_W     (CNT_W),
    .MAX_WORDS (MAX_WORDS)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .first      (cnt_first),
    .base       (bus.cfg_mem_addr),
    .len        (bus.cfg_len),
    .inc        (cnt_inc),
    .addr_c     (cnt_addr_c),
    .at_limit_c (cnt_at_limit_c),
    .last_c     (cnt_last_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_start) begin
          if (bus.cfg_dir == DIR_DEV2MEM) state_d = S_WAIT_REQ;
          else if (bus.cfg_len != '0)     state_d = S_XFER_WR;
          else                            state_d = S_DONE;
        end
      end
      S_WAIT_REQ: if (bus.gpio_req) state_d = S_XFER_RD;
      // The last capture and the termination share one edge, so ack never
      // covers a word that will not be taken.
      S_XFER_RD: if (!bus.gpio_req || cnt_at_limit_c || cnt_last_c) state_d = S_DONE;
      // Leave only once all reads are issued and the final read has been returned.
      S_XFER_WR: if (cnt_at_limit_c && !mem_re_q) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_first    = 1'b0;
    cnt_inc      = 1'b0;
    ack_d        = 1'b0;
    io_write_d   = 1'b0;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    word_count_d = word_count_q;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_start) begin
          cnt_load     = 1'b1;
          word_count_d = '0;
          // Word 0 read goes out straight from the config so it lands in the next cycle.
          if ((bus.cfg_dir == DIR_MEM2DEV) && (bus.cfg_len != '0)) begin
            cnt_first  = 1'b1;
            mem_re_d   = 1'b1;
            mem_addr_d = bus.cfg_mem_addr;
          end
        end
      end
      S_WAIT_REQ: ack_d = bus.gpio_req;
      S_XFER_RD: begin
        if (bus.gpio_req && !cnt_at_limit_c) begin
          cnt_inc      = 1'b1;
          mem_we_d     = 1'b1;
          mem_addr_d   = cnt_addr_c;
          mem_wdata_d  = bus.dev_rdata;
          word_count_d = word_count_q + CNT_W'(1);
          ack_d        = !cnt_last_c;
        end
      end
      S_XFER_WR: begin
        if (!cnt_at_limit_c) begin
          cnt_inc    = 1'b1;
          mem_re_d   = 1'b1;
          mem_addr_d = cnt_addr_c;
        end
        // Stage 2 follows each read by one cycle, when its data is on mem_rdata.
        ack_d      = mem_re_q;
        io_write_d = mem_re_q;
        if (io_write_q) word_count_d = word_count_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q        <= 1'b0;
      io_write_q   <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      word_count_q <= '0;
    end else begin
      ack_q        <= ack_d;
      io_write_q   <= io_write_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      word_count_q <= word_count_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.io_write   = io_write_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.word_count = word_count_q;
  // Read data is forwarded in the cycle it returns; zero whenever not writing the device.
  assign bus.dev_wdata  = io_write_q ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dma_io_channel.sv
// Scoreboard bench for dma_io_channel: expected memory writes, device writes
// and done/word_count values are queued by the stimulus and popped by a
// negedge monitor whenever the DUT presents them.
module tb_dma_io_channel;

  logic clk;
  logic rst;

  dma_io_channel_if bus ();

  dma_io_channel dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_target = 0;
  int re_count = 0;

  logic [39:0] exp_wr[$];
  logic [31:0] exp_dev[$];
  logic [4:0]  exp_done[$];
  logic [31:0] mem[256];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_re) re_count++;
      if (bus.mem_we) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_write: got addr 0x%0h data 0x%0h required no write", bus.mem_addr, bus.mem_wdata);
        end else chk("mem_write", {24'h0, bus.mem_addr, bus.mem_wdata}, {24'h0, exp_wr.pop_front()});
      end
      if (bus.ack && bus.io_write) begin
        if (exp_dev.size() == 0) begin
          checks++; errors++;
          $display("FAIL dev_write: got 0x%0h required no write", bus.dev_wdata);
        end else chk("dev_write", {32'h0, bus.dev_wdata}, {32'h0, exp_dev.pop_front()});
      end
      if (bus.done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL done: got word_count %0d required no done", bus.word_count);
        end else chk("done_word_count", {59'h0, bus.word_count}, {59'h0, exp_done.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {45'h0, bus.ack, bus.io_write, bus.mem_re, bus.mem_we, bus.busy, bus.done,
                         bus.word_count, bus.mem_addr}, 64'h0);
    chk({name, "_data"}, {bus.dev_wdata, bus.mem_wdata}, 64'h0);
  endtask

  task automatic start(input logic dir, input logic [7:0] addr, input logic [4:0] len);
    bus.cfg_dir      = dir;
    bus.cfg_mem_addr = addr;
    bus.cfg_len      = len;
    bus.cfg_start    = 1'b1;
    done_target      = done_cnt + 1;
    step();
    bus.cfg_start = 1'b0;
    chk("busy_after_start", {63'h0, bus.busy}, 64'h1);
  endtask

  task automatic wait_ack();
    bit got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (bus.ack) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no ack required ack within 20 cycles");
    end
  endtask

  // Device raises request, then presents one word per cycle from the first ack cycle.
  task automatic dev_send(input int n, input logic [31:0] first);
    bus.gpio_req = 1'b1;
    wait_ack();
    for (int i = 0; i < n; i++) begin
      bus.dev_rdata = first + 32'(i);
      step();
    end
    bus.gpio_req  = 1'b0;
    bus.dev_rdata = '0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt < done_target && k < 100) begin
      step();
      k++;
    end
    chk("done_seen", {63'h0, done_cnt >= done_target}, 64'h1);
    step();
  endtask

  initial begin
    int re_before;
    rst              = 1'b1;
    bus.cfg_start    = 1'b0;
    bus.cfg_dir      = 1'b0;
    bus.cfg_mem_addr = '0;
    bus.cfg_len      = '0;
    bus.gpio_req     = 1'b0;
    bus.dev_rdata    = '0;
    bus.mem_rdata    = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk("idle_busy", {63'h0, bus.busy}, 64'h0);

    // dir 0, run-until-drop: 5,6,7 to 0x10..0x12.
    exp_wr.push_back({8'h10, 32'd5});
    exp_wr.push_back({8'h11, 32'd6});
    exp_wr.push_back({8'h12, 32'd7});
    exp_done.push_back(5'd3);
    start(1'b0, 8'h10, 5'd0);
    dev_send(3, 32'd5);
    wait_done();
    chk("ack_low_after", {63'h0, bus.ack}, 64'h0);
    chk("wc_held", {59'h0, bus.word_count}, 64'd3);

    // dir 0, len 2 with 3 words offered; a start pulse while busy is ignored.
    re_before = re_count;
    exp_wr.push_back({8'h80, 32'h200});
    exp_wr.push_back({8'h81, 32'h201});
    exp_done.push_back(5'd2);
    start(1'b0, 8'h80, 5'd2);
    bus.cfg_dir = 1'b1; bus.cfg_mem_addr = 8'h50; bus.cfg_len = 5'd5; bus.cfg_start = 1'b1;
    step();
    bus.cfg_start = 1'b0;
    dev_send(3, 32'h200);
    wait_done();
    chk("busy_start_no_reads", 64'(re_count - re_before), 64'd0);

    // dir 1, len 4 from 0xFE with wrap; done six cycles after start.
    mem[8'hFE] = 32'hA; mem[8'hFF] = 32'hB; mem[8'h00] = 32'hC; mem[8'h01] = 32'hD;
    exp_dev.push_back(32'hA); exp_dev.push_back(32'hB);
    exp_dev.push_back(32'hC); exp_dev.push_back(32'hD);
    exp_done.push_back(5'd4);
    start(1'b1, 8'hFE, 5'd4);
    chk("wr_first_re", {55'h0, bus.mem_re, bus.mem_addr}, {55'h0, 1'b1, 8'hFE});
    step();
    step();
    chk("wr_wrap_addr", {55'h0, bus.mem_re, bus.mem_addr}, {55'h0, 1'b1, 8'h00});
    step();
    step();
    step();
    chk("wr_done_latency", {62'h0, bus.done, bus.ack}, {62'h0, 1'b1, 1'b0});
    wait_done();

    // dir 0, len 0, request held 40 cycles: capped at 31 words.
    for (int i = 0; i < 31; i++) exp_wr.push_back({8'(8'h40 + 8'(i)), 32'(100 + i)});
    exp_done.push_back(5'd31);
    start(1'b0, 8'h40, 5'd0);
    dev_send(40, 32'd100);
    wait_done();

    // Reset after 2 words of a 5-word transfer.
    exp_wr.push_back({8'h20, 32'h300});
    exp_wr.push_back({8'h21, 32'h301});
    start(1'b0, 8'h20, 5'd5);
    bus.gpio_req = 1'b1;
    wait_ack();
    bus.dev_rdata = 32'h300;
    step();
    bus.dev_rdata = 32'h301;
    step();
    bus.dev_rdata = 32'h302;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    bus.gpio_req = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk("post_reset_idle", {62'h0, bus.busy, bus.mem_we}, 64'h0);

    // New transfer after reset works.
    exp_wr.push_back({8'h30, 32'h400});
    exp_done.push_back(5'd1);
    start(1'b0, 8'h30, 5'd1);
    dev_send(1, 32'h400);
    wait_done();

    // dir 1, len 0: immediate done, no memory reads.
    re_before = re_count;
    exp_done.push_back(5'd0);
    start(1'b1, 8'h60, 5'd0);
    chk("len0_done_now", {63'h0, bus.done}, 64'h1);
    wait_done();
    chk("len0_no_reads", 64'(re_count - re_before), 64'd0);

    chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    chk("dev_queue_empty", 64'(exp_dev.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_done.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
